// File: rtl/if_id_stage_if.sv
// Bus between the fetch stage, the IF/ID register and the hazard consumers.
// The master side is fetch/EX/control, and the slave side is the IF/ID stage.
interface if_id_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_ir;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_npc;
    logic            br_taken;
    logic            ext_stall;
    logic            ex_mem_read;
    logic [4:0]      ex_rt;
    logic [XLEN-1:0] id_ir;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_npc;
    logic            id_valid;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic            stall_o;
    logic            ex_bubble;
    logic [31:0]     stall_cnt;

    modport master (
        output if_ir, if_pc, if_npc, br_taken, ext_stall, ex_mem_read, ex_rt,
        input  id_ir, id_pc, id_npc, id_valid, id_rs, id_rt, stall_o, ex_bubble, stall_cnt
    );

    modport slave (
        input  if_ir, if_pc, if_npc, br_taken, ext_stall, ex_mem_read, ex_rt,
        output id_ir, id_pc, id_npc, id_valid, id_rs, id_rt, stall_o, ex_bubble, stall_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a load-use hazard detector.
// A load in EX whose destination feeds the instruction in ID stalls fetch for
// one cycle and pushes a bubble into ID/EX. The HOLD state masks the hazard on
// the following cycle, so each load costs exactly one stall.
module if_id_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = '0,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    if_id_stage_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [5:0] opcode;
    logic       uses_rt;
    logic       haz;

    // Decode the held instruction's register fields and flag a load-use hazard against EX.
    always_comb begin
        opcode    = bus.id_ir[31:26];
        bus.id_rs = bus.id_ir[25:21];
        bus.id_rt = bus.id_ir[20:16];
        uses_rt   = (opcode == 6'h00) || (opcode == 6'h2B) ||
                    (opcode == 6'h04) || (opcode == 6'h05);
        haz       = bus.id_valid && (state == RUN) && bus.ex_mem_read &&
                    (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (uses_rt && (bus.ex_rt == bus.id_rt)));
        bus.stall_o   = haz || bus.ext_stall;
        bus.ex_bubble = haz && !bus.ext_stall && !bus.br_taken;
    end

    // Pipeline register update: reset, then flush, then freeze, then hazard hold, then load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.id_ir     <= NOP_INST;
            bus.id_pc     <= RESET_PC;
            bus.id_npc    <= RESET_PC;
            bus.id_valid  <= 1'b0;
            bus.stall_cnt <= 32'd0;
            state         <= RUN;
        end else if (bus.br_taken) begin
            bus.id_ir    <= NOP_INST;
            bus.id_pc    <= RESET_PC;
            bus.id_npc   <= RESET_PC;
            bus.id_valid <= 1'b0;
            state        <= RUN;
        end else if (!bus.ext_stall) begin
            if (haz) begin
                bus.stall_cnt <= bus.stall_cnt + 32'd1;
                state         <= HOLD;
            end else begin
                bus.id_ir    <= bus.if_ir;
                bus.id_pc    <= bus.if_pc;
                bus.id_npc   <= bus.if_npc;
                bus.id_valid <= 1'b1;
                state        <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: a directed vector table for the named scenarios,
// then randomized traffic compared against a behavioural pipeline model.
module tb_if_id_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_id_stage_if #(.XLEN(32)) bus();

    if_id_stage #(
        .XLEN(32),
        .NOP_INST(32'h0000_0000),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        br;
        logic        ext;
        logic        mr;
        logic [4:0]  exRt;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] npc;
        bit          chkComb;
        logic        expStall;
        logic        expBub;
        logic [31:0] expIr;
        logic [31:0] expPc;
        logic [31:0] expNpc;
        logic        expValid;
        logic [31:0] expCnt;
    } vec_t;

    // Behavioural model of the stage.
    logic [31:0] mIr;
    logic [31:0] mPc;
    logic [31:0] mNpc;
    bit          mValid;
    bit          mJustStalled;
    logic [31:0] mCnt;
    bit          modelKnown;

    function automatic vec_t mk(
        input logic rst_, input logic br, input logic ext, input logic mr,
        input int exRt, input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] npc,
        input bit chk, input logic st, input logic bub,
        input logic [31:0] eIr, input logic [31:0] ePc, input logic [31:0] eNpc,
        input logic eValid, input logic [31:0] eCnt);
        vec_t v;
        v.rst = rst_; v.br = br; v.ext = ext; v.mr = mr; v.exRt = 5'(exRt);
        v.ir = ir; v.pc = pc; v.npc = npc;
        v.chkComb = chk; v.expStall = st; v.expBub = bub;
        v.expIr = eIr; v.expPc = ePc; v.expNpc = eNpc; v.expValid = eValid; v.expCnt = eCnt;
        return v;
    endfunction

    // The held instruction reads the loaded register: rs always, rt only for R-type, sw, beq and bne.
    function automatic bit modelHaz();
        int op;
        int rs;
        int rt;
        bit readsRt;
        op = int'(mIr / 32'h0400_0000);
        rs = int'((mIr / 32'h0020_0000) % 32);
        rt = int'((mIr / 32'h0001_0000) % 32);
        readsRt = (op == 0) || (op == 43) || (op == 4) || (op == 5);
        if (!mValid || mJustStalled || !bus.ex_mem_read || bus.ex_rt == 5'd0)
            return 1'b0;
        return (int'(bus.ex_rt) == rs) || (readsRt && int'(bus.ex_rt) == rt);
    endfunction

    task automatic modelUpdate();
        bit h;
        h = modelHaz();
        if (!rst) begin
            mIr = 32'h0; mPc = 32'h0; mNpc = 32'h0; mValid = 0; mJustStalled = 0; mCnt = 32'h0;
            modelKnown = 1;
        end else if (bus.br_taken) begin
            mIr = 32'h0; mPc = 32'h0; mNpc = 32'h0; mValid = 0; mJustStalled = 0;
        end else if (bus.ext_stall) begin
            // Frozen: nothing moves.
        end else if (h) begin
            mJustStalled = 1;
            mCnt = mCnt + 32'd1;
        end else begin
            mIr = bus.if_ir; mPc = bus.if_pc; mNpc = bus.if_npc; mValid = 1; mJustStalled = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        bus.br_taken    = v.br;
        bus.ext_stall   = v.ext;
        bus.ex_mem_read = v.mr;
        bus.ex_rt       = v.exRt;
        bus.if_ir       = v.ir;
        bus.if_pc       = v.pc;
        bus.if_npc      = v.npc;
    endtask

    // One clock: drive, check the combinational outputs, take the edge, check the registers.
    task automatic runCycle(input vec_t v, input bit useTable);
        bit h;
        applyStimulus(v);
        #2;
        h = modelHaz();
        if (useTable) begin
            if (v.chkComb) begin
                checkOutput("stall_o", 32'(bus.stall_o), 32'(v.expStall));
                checkOutput("ex_bubble", 32'(bus.ex_bubble), 32'(v.expBub));
            end
        end else if (modelKnown) begin
            checkOutput("stall_o", 32'(bus.stall_o), 32'(h || bus.ext_stall));
            checkOutput("ex_bubble", 32'(bus.ex_bubble), 32'(h && !bus.ext_stall && !bus.br_taken));
            checkOutput("id_rs", 32'(bus.id_rs), (mIr / 32'h0020_0000) % 32);
            checkOutput("id_rt", 32'(bus.id_rt), (mIr / 32'h0001_0000) % 32);
        end
        @(posedge clk);
        modelUpdate();
        #1;
        if (useTable) begin
            checkOutput("id_ir", bus.id_ir, v.expIr);
            checkOutput("id_pc", bus.id_pc, v.expPc);
            checkOutput("id_npc", bus.id_npc, v.expNpc);
            checkOutput("id_valid", 32'(bus.id_valid), 32'(v.expValid));
            checkOutput("stall_cnt", bus.stall_cnt, v.expCnt);
        end else begin
            checkOutput("id_ir", bus.id_ir, mIr);
            checkOutput("id_pc", bus.id_pc, mPc);
            checkOutput("id_npc", bus.id_npc, mNpc);
            checkOutput("id_valid", 32'(bus.id_valid), 32'(mValid));
            checkOutput("stall_cnt", bus.stall_cnt, mCnt);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [5:0] ops [6];
        vec_t       r;
        checks = 0;
        errors = 0;
        modelKnown = 0;
        mIr = '0; mPc = '0; mNpc = '0; mValid = 0; mJustStalled = 0; mCnt = '0;
        ops = '{6'h00, 6'h2B, 6'h04, 6'h05, 6'h23, 6'h08};

        //         rst br ext mr exRt ir            pc       npc      chk st bub expIr         expPc    expNpc   vld cnt
        // Reset held for two cycles.
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8C080004, 32'h00, 32'h04, 0, 0, 0, 32'h00000000, 32'h00, 32'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8C080004, 32'h00, 32'h04, 1, 0, 0, 32'h00000000, 32'h00, 32'h00, 0, 0));
        // Stream: lw, then add $9,$8,$8 enters ID.
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h8C080004, 32'h00, 32'h04, 1, 0, 0, 32'h8C080004, 32'h00, 32'h04, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h01084820, 32'h04, 32'h08, 1, 0, 0, 32'h01084820, 32'h04, 32'h08, 1, 0));
        // Load-use on $8: one stall cycle, then the held instruction advances.
        vecs.push_back(mk(1, 0, 0, 1, 8, 32'h22220000, 32'h08, 32'h0C, 1, 1, 1, 32'h01084820, 32'h04, 32'h08, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8, 32'h22220000, 32'h08, 32'h0C, 1, 0, 0, 32'h22220000, 32'h08, 32'h0C, 1, 1));
        // ex_rt=0 never hazards; addi with ex_rt matching only its rt does not hazard.
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h21090001, 32'h0C, 32'h10, 1, 0, 0, 32'h21090001, 32'h0C, 32'h10, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 9, 32'h01084820, 32'h10, 32'h14, 1, 0, 0, 32'h01084820, 32'h10, 32'h14, 1, 1));
        // Flush in the hazard cycle: no bubble, ID squashed, counter untouched.
        vecs.push_back(mk(1, 1, 0, 1, 8, 32'h11111111, 32'h14, 32'h18, 1, 1, 0, 32'h00000000, 32'h00, 32'h00, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h01084820, 32'h20, 32'h24, 1, 0, 0, 32'h01084820, 32'h20, 32'h24, 1, 1));
        // Three frozen cycles with changing fetch data, then release.
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hAAAA0000, 32'h30, 32'h34, 1, 1, 0, 32'h01084820, 32'h20, 32'h24, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hBBBB0000, 32'h40, 32'h44, 1, 1, 0, 32'h01084820, 32'h20, 32'h24, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hCCCC0000, 32'h50, 32'h54, 1, 1, 0, 32'h01084820, 32'h20, 32'h24, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'hDDDD0000, 32'h60, 32'h64, 1, 0, 0, 32'hDDDD0000, 32'h60, 32'h64, 1, 1));
        // Hazard on rs=14, then reset while in the hold cycle under a freeze.
        vecs.push_back(mk(1, 0, 0, 1, 14, 32'h01084820, 32'h70, 32'h74, 1, 1, 1, 32'hDDDD0000, 32'h60, 32'h64, 1, 2));
        vecs.push_back(mk(0, 0, 1, 1, 14, 32'h01084820, 32'h70, 32'h74, 1, 1, 0, 32'h00000000, 32'h00, 32'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h01084820, 32'h70, 32'h74, 1, 0, 0, 32'h01084820, 32'h70, 32'h74, 1, 0));

        foreach (vecs[i]) runCycle(vecs[i], 1'b1);
        $display("[TB] directed table done");

        for (int n = 0; n < 400; n++) begin
            r.rst  = ($urandom_range(0, 49) != 0);
            r.br   = ($urandom_range(0, 7) == 0);
            r.ext  = ($urandom_range(0, 5) == 0);
            r.mr   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       r.exRt = 5'd0;
                1:       r.exRt = mIr[25:21];
                2:       r.exRt = mIr[20:16];
                default: r.exRt = 5'($urandom_range(0, 31));
            endcase
            r.ir  = {ops[$urandom_range(0, 5)], 26'($urandom)};
            r.pc  = $urandom & 32'hFFFF_FFFC;
            r.npc = r.pc + 32'd4;
            r.chkComb = 0; r.expStall = 0; r.expBub = 0;
            r.expIr = '0; r.expPc = '0; r.expNpc = '0; r.expValid = 0; r.expCnt = '0;
            runCycle(r, 1'b0);
        end
        $display("[TB] random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
